// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package regfile_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned DepthDefault = 32;

  typedef enum logic {
    StClear,
    StReady
  } rf_state_e;

  // Bit offset of lane k within a packed multi-lane bus of lane width w.
  function automatic int unsigned lane_off(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Reset-driven clear sequencer: walks the array one entry per cycle, then
// parks in READY with the counter held.
module reg_file_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = DepthDefault,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      unique case (state_q)
        StClear: begin
          // Last entry is being zeroed at this edge; busy drops with it.
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        StReady: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= StClear;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = busy_q;
  assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with bypass, optional zero register and a
// sequenced clear. Optional debug read port: REGFILE_DEBUG_PORT_EN.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DataWDefault,
  parameter int unsigned DEPTH    = DepthDefault,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     busy
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_rdata
`endif
);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic [DATA_W-1:0] mem_q [DEPTH];

  reg_file_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A user write is live only in READY and never to a hardwired zero register.
  assign wr_ok = we && !busy && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_lane
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[lane_off(k, ADDR_W) +: ADDR_W];

    always_comb begin
      rd = mem_q[ra];
      if (busy) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if (wr_ok && (waddr == ra)) begin
        rd = wdata;
      end
    end

    assign rdata[lane_off(k, DATA_W) +: DATA_W] = rd;
  end

`ifdef REGFILE_DEBUG_PORT_EN
  logic [DATA_W-1:0] dbg_rdata_q;

  always_ff @(posedge clk) begin
    if (rst || busy) begin
      dbg_rdata_q <= '0;
    end else begin
      dbg_rdata_q <= mem_q[dbg_addr];
    end
  end

  assign dbg_rdata = dbg_rdata_q;
`else
  // Default build has no debug read path.
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (DATA_W=32, DEPTH=32, NUM_RD=2).
module tb_reg_file_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic           clk;
  logic           rst;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic           busy;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [AW-1:0]  dbg_addr;
  logic [DW-1:0]  dbg_rdata;
`endif

  int checks;
  int failures;

  reg_file_mp #(
    .DATA_W   (DW),
    .DEPTH    (32),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .busy     (busy)
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_rdata(dbg_rdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lane(input int k);
    return rdata[k*DW +: DW];
  endfunction

  task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy: got %b want 1", busy);
    end
    set_raddr(5'd0, 5'd17);
    #1;
    checks++;
    if (rdata !== '0) begin
      failures++;
      $display("FAIL clear_rdata_zero: got %h want 0", rdata);
    end
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_addr = 5'd31;
`endif
    n = 1;
    while (busy === 1'b1 && n < 100) begin
      tick();
`ifdef REGFILE_DEBUG_PORT_EN
      if (busy === 1'b1) begin
        checks++;
        if (dbg_rdata !== '0) begin
          failures++;
          $display("FAIL dbg_busy_zero: got %h want 0", dbg_rdata);
        end
      end
`endif
      if (busy === 1'b1) n++;
    end
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL clear_cycles: got %0d want 32", n);
    end
    for (int i = 0; i < 32; i++) begin
      set_raddr(AW'(i), AW'(31 - i));
      #1;
      checks++;
      if (rdata !== '0) begin
        failures++;
        $display("FAIL post_clear_read[%0d]: got %h want 0", i, rdata);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(5'd7, 32'hDEADBEEF);
    set_raddr(5'd7, 5'd7);
    #1;
    checks++;
    if (lane(0) !== 32'hDEADBEEF || lane(1) !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_read: got %h/%h want deadbeef", lane(0), lane(1));
    end
  endtask

  task automatic test_bypass();
    do_write(5'd6, 32'h0BADF00D);
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678;
    set_raddr(5'd5, 5'd6);
    #1;
    checks++;
    if (lane(0) !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_lane0: got %h want 12345678", lane(0));
    end
    checks++;
    if (lane(1) !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL bypass_lane1_old: got %h want 0badf00d", lane(1));
    end
    set_raddr(5'd5, 5'd5);
    #1;
    checks++;
    if (lane(0) !== 32'h12345678 || lane(1) !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_both: got %h/%h want 12345678", lane(0), lane(1));
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (lane(1) !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_stored: got %h want 12345678", lane(1));
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    set_raddr(5'd0, 5'd0);
    #1;
    checks++;
    if (rdata !== '0) begin
      failures++;
      $display("FAIL zero_bypass: got %h want 0", rdata);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rdata !== '0) begin
      failures++;
      $display("FAIL zero_stored: got %h want 0", rdata);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_raddr(5'd3, 5'd7);
    n = 1;
    while (busy === 1'b1 && n < 100) begin
      we = (n == 6);
      waddr = 5'd3;
      wdata = 32'hCAFEF00D;
      #1;
      if (n == 6) begin
        checks++;
        if (rdata !== '0) begin
          failures++;
          $display("FAIL busy_no_bypass: got %h want 0", rdata);
        end
      end
      tick();
      if (busy === 1'b1) n++;
    end
    we = 1'b0;
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL restart_cycles: got %0d want 32", n);
    end
    #1;
    checks++;
    if (lane(0) !== '0) begin
      failures++;
      $display("FAIL dropped_write_reg3: got %h want 0", lane(0));
    end
    checks++;
    if (lane(1) !== '0) begin
      failures++;
      $display("FAIL reg7_cleared: got %h want 0", lane(1));
    end
  endtask

`ifdef REGFILE_DEBUG_PORT_EN
  task automatic test_debug();
    do_write(5'd31, 32'hA5A5A5A5);
    dbg_addr = 5'd31;
    tick();
    checks++;
    if (dbg_rdata !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL dbg_read: got %h want a5a5a5a5", dbg_rdata);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    we = 1'b0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_addr = '0;
`endif
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_reset_mid_clear();
`ifdef REGFILE_DEBUG_PORT_EN
    test_debug();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-read-port general-purpose register file, the successor to the single-write/two-read register file in the CPU datapath. Adds:
- configurable width, depth and read-port count
- optional hardwired zero register
- write-to-read bypass
- a reset-driven clear sequencer that zeroes the array one entry per cycle, so the array can map to RAM without a global reset fan-out

It sits between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers; must be a power of two, at least 2
ADDR_W, 5, address width; must equal log2(DEPTH)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is ordinary storage

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
raddr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
busy  out  1  high while the clear sequencer runs; writes are ignored while high

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State machine states: CLEAR, READY.
- Reset behaviour: rst=1 at an edge sets state=CLEAR, clear counter clr_cnt=0 and busy=1.
  - rst asserted mid-clear restarts the counter at 0.
  - rst asserted in READY re-enters CLEAR.
- CLEAR state:
  - Each cycle writes 0 to registers[clr_cnt], then clr_cnt increments.
  - When clr_cnt==DEPTH-1 is written, the next state is READY and busy falls at that same edge.
  - A full clear takes exactly DEPTH cycles after the last rst-high edge.
  - The counter does not wrap; it is held once READY is reached.
- During CLEAR:
  - Every rdata lane reads 0, regardless of array contents.
  - we is ignored; the write is dropped, not queued.
- READY writes: registers[waddr] <= wdata at the rising edge when we=1. With ZERO_REG=1 and waddr==0 the write is dropped.
- READY reads: combinational, zero latency. Lane k returns registers[raddr_k], with these overrides:
  - With ZERO_REG=1 and raddr_k==0, lane k returns 0.
  - Bypass: if we=1 and waddr==raddr_k (and that write is not dropped), lane k returns wdata in the same cycle.
  - Multiple lanes may read the same address; all see identical data, including any bypass.
- Outputs at reset: busy=1. rdata is all-zero throughout CLEAR.
- No X may appear on rdata after reset. All storage is defined by the clear sequence.

Optional Feature:
Macro REGFILE_DEBUG_PORT_EN.
- Defined: adds ports dbg_addr (in, ADDR_W) and dbg_rdata (out, DATA_W).
  - dbg_rdata is a registered read of registers[dbg_addr], giving 1-cycle latency.
  - No bypass on this port.
  - dbg_rdata resets to 0 and reads 0 while busy.
  - Used by the testbench and the OS-level debug monitor in place of the simulation-time register dump.
- Undefined: these ports and their logic do not exist; the port list is exactly as above.

Decomposition:
- Shared package regfile_pkg holds:
  - state enum CLEAR/READY
  - default DATA_W/DEPTH constants
  - a function computing the lane slice offset
- One natural sub-module: reg_file_clear_seq, containing the FSM plus clr_cnt. It outputs busy, clr_we and clr_addr, which are muxed onto the array write port ahead of the user write.
- Read lanes are a generate loop in the top module.

Test Plan:
1. Clear timing: pulse rst for 1 cycle with DEPTH=32 -> busy high for exactly 32 cycles; every raddr then reads 0x00000000.
2. Write then read: write 0xDEADBEEF to reg 7, next cycle read it on lanes 0 and 1 -> both lanes return 0xDEADBEEF.
3. Bypass: we=1, waddr=5, wdata=0x12345678, raddr0=5 in the same cycle -> rdata lane 0 is 0x12345678 combinationally; raddr1=6 returns its old value.
4. Zero register: ZERO_REG=1, write 0xFFFFFFFF to reg 0 -> lane read of reg 0 returns 0, including the same-cycle bypass case.
5. Reset mid-clear: assert rst at clear cycle 10 -> busy stays high for 32 more cycles. A write to reg 3 issued during busy is lost; reg 3 reads 0.
6. With REGFILE_DEBUG_PORT_EN defined: write 0xA5A5A5A5 to reg 31, set dbg_addr=31 -> dbg_rdata shows 0xA5A5A5A5 one cycle later; it showed 0 while busy.
